// File: rtl/data_island_packet_serializer.sv
// rtl/data_island_packet_serializer.sv - one-entry packet hold plus 32-cycle data-island serializer with sequential BCH parity.
// Optional SERIALIZER_STATS_EN adds sent-packet and sent-null counters.
module data_island_packet_serializer #(
    parameter int NULL_WHEN_EMPTY = 1
) (
    input  logic        clk_pixel,
    input  logic        reset,
    input  logic        island_active,
    input  logic        pkt_valid,
    output logic        pkt_ready,
    input  logic [23:0] header,
    input  logic [55:0] sub0,
    input  logic [55:0] sub1,
    input  logic [55:0] sub2,
    input  logic [55:0] sub3,
    output logic [8:0]  packet_data,
    output logic        pdata_valid,
    output logic [4:0]  pdata_index,
    output logic        pdata_start
`ifdef SERIALIZER_STATS_EN
    ,
    output logic [15:0] pkt_sent_count,
    output logic [15:0] null_sent_count
`endif
);

    function automatic logic [7:0] ecc_step(input logic [7:0] e, input logic b);
        return (e >> 1) ^ (((e[0] ^ b) != 1'b0) ? 8'h83 : 8'h00);
    endfunction

    logic        hold_full;
    logic [23:0] hold_hdr;
    logic [55:0] hold_sub [4];
    logic [23:0] cur_hdr;
    logic [55:0] cur_sub [4];
    logic        cur_null;
    logic [4:0]  slot_cnt;
    logic [7:0]  hecc;
    logic [7:0]  secc [4];

    logic        at_start;
    logic        running;
    logic        load_hold;
    logic [23:0] src_hdr;
    logic [55:0] src_sub [4];
    logic        src_null;
    logic [31:0] hdr_pad;
    logic [63:0] sub_pad;
    logic [7:0]  hecc_in;
    logic [7:0]  secc_in;
    logic        hbit;
    logic [3:0]  ev;
    logic [3:0]  od;
    logic [7:0]  hecc_nx;
    logic [7:0]  secc_nx [4];
    logic [8:0]  pdata_nx;

    assign pkt_ready = ~hold_full;

    always_comb begin
        at_start  = (slot_cnt == 5'd0);
        running   = island_active && (!at_start || hold_full || (NULL_WHEN_EMPTY != 0));
        load_hold = island_active && at_start && hold_full;
        // Position 0 is emitted from the packet being loaded in that same cycle.
        src_hdr   = cur_hdr;
        src_sub   = cur_sub;
        src_null  = cur_null;
        if (at_start) begin
            src_hdr  = hold_full ? hold_hdr : 24'h0;
            for (int n = 0; n < 4; n++) src_sub[n] = hold_full ? hold_sub[n] : 56'h0;
            src_null = !hold_full;
        end
        hdr_pad = {8'h00, src_hdr};
        hecc_in = at_start ? 8'h00 : hecc;
        if (slot_cnt < 5'd24) begin
            hbit    = hdr_pad[slot_cnt];
            hecc_nx = ecc_step(hecc_in, hbit);
        end else begin
            hbit    = hecc[slot_cnt[2:0]];
            hecc_nx = hecc;
        end
        sub_pad = 64'h0;
        secc_in = 8'h00;
        ev      = 4'h0;
        od      = 4'h0;
        for (int n = 0; n < 4; n++) begin
            sub_pad = {8'h00, src_sub[n]};
            secc_in = at_start ? 8'h00 : secc[n];
            if (slot_cnt < 5'd28) begin
                ev[n]      = sub_pad[{slot_cnt, 1'b0}];
                od[n]      = sub_pad[{slot_cnt, 1'b1}];
                secc_nx[n] = ecc_step(ecc_step(secc_in, ev[n]), od[n]);
            end else begin
                ev[n]      = secc[n][{slot_cnt[1:0], 1'b0}];
                od[n]      = secc[n][{slot_cnt[1:0], 1'b1}];
                secc_nx[n] = secc[n];
            end
        end
        pdata_nx = {od, ev, hbit};
    end

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            hold_full   <= 1'b0;
            hold_hdr    <= 24'h0;
            hold_sub    <= '{default: 56'h0};
            cur_hdr     <= 24'h0;
            cur_sub     <= '{default: 56'h0};
            cur_null    <= 1'b0;
            slot_cnt    <= 5'd0;
            hecc        <= 8'h00;
            secc        <= '{default: 8'h00};
            packet_data <= 9'h000;
            pdata_valid <= 1'b0;
            pdata_index <= 5'd0;
            pdata_start <= 1'b0;
        end else begin
            if (pkt_valid && !hold_full) begin
                hold_full <= 1'b1;
                hold_hdr  <= header;
                hold_sub  <= '{sub0, sub1, sub2, sub3};
            end else if (load_hold) begin
                hold_full <= 1'b0;
            end
            if (running) begin
                slot_cnt    <= slot_cnt + 5'd1;
                hecc        <= hecc_nx;
                secc        <= secc_nx;
                packet_data <= pdata_nx;
                pdata_valid <= 1'b1;
                pdata_index <= slot_cnt;
                pdata_start <= at_start;
                if (at_start) begin
                    cur_hdr  <= src_hdr;
                    cur_sub  <= src_sub;
                    cur_null <= src_null;
                end
            end else begin
                // Idle, stalled on an empty hold, or aborted mid-slot.
                slot_cnt    <= 5'd0;
                packet_data <= 9'h000;
                pdata_valid <= 1'b0;
                pdata_index <= 5'd0;
                pdata_start <= 1'b0;
            end
        end
    end

`ifdef SERIALIZER_STATS_EN
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            pkt_sent_count  <= 16'h0;
            null_sent_count <= 16'h0;
        end else if (running && slot_cnt == 5'd31) begin
            if (cur_null) begin
                if (null_sent_count != 16'hFFFF) null_sent_count <= null_sent_count + 16'h1;
            end else begin
                if (pkt_sent_count != 16'hFFFF) pkt_sent_count <= pkt_sent_count + 16'h1;
            end
        end
    end
`endif

endmodule
